mbus_initiator: RTL

Bus-master counterpart of the on-chip SRAMs on `memory_bus`. It takes single load/store requests from the core's LSU/fetch port, converts byte addresses to word addresses and byte-lane strobes, and drives a one-cycle read/write strobe on `memory_bus.master`. It waits for the responder's `ready`, aligns and sign/zero-extends load data, and returns one response per request. A watchdog turns a missing `ready` into an error response instead of a hang.

---
 rtl/mbus_initiator.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mbus_initiator.sv
// Single-outstanding load/store master for the on-chip SRAM bus: byte address to word
// address + lane strobes, one-cycle read/write strobe, ready watchdog, load alignment.
module mbus_initiator #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mbus_addr_o,
  output logic [31:0]       mbus_data_d_o,
  output logic [3:0]        mbus_byte_sel_o,
  output logic              mbus_read_o,
  output logic              mbus_write_o,
  input  logic [31:0]       mbus_data_q_i,
  input  logic              mbus_ready_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [31:0]         bdata_q, bdata_d;
  logic [3:0]          bsel_q, bsel_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic                we_q, we_d, uns_q, uns_d;
  logic [1:0]          lane_q, lane_d, size_q, size_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                bad_s;

  // Shift the addressed lane down to bit 0, then sign/zero-extend by access size.
  function automatic logic [31:0] align_load(input logic [31:0] q, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = q >> {lane, 3'b000};
    case (size)
      2'd0:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign bad_s = (req_size_i == 2'd3)
               || ((req_size_i == 2'd1) && req_addr_i[0])
               || ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'd0))
               || ((req_addr_i >> (ADDR_W + 2)) != 32'd0);

  // Next-state, bus field and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    baddr_d      = baddr_q;
    bdata_d      = bdata_q;
    bsel_d       = bsel_q;
    we_d         = we_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    size_d       = size_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (bad_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_STROBE;
            baddr_d = req_addr_i[ADDR_W+1:2];
            we_d    = req_we_i;
            uns_d   = req_unsigned_i;
            lane_d  = req_addr_i[1:0];
            size_d  = req_size_i;
            rd_d    = ~req_we_i;
            wr_d    = req_we_i;
            case (req_size_i)
              2'd0: begin
                bsel_d  = 4'b0001 << req_addr_i[1:0];
                bdata_d = {4{req_wdata_i[7:0]}};
              end
              2'd1: begin
                bsel_d  = 4'b0011 << req_addr_i[1:0];
                bdata_d = {2{req_wdata_i[15:0]}};
              end
              default: begin
                bsel_d  = 4'hF;
                bdata_d = req_wdata_i;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mbus_ready_i) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'd0 : align_load(mbus_data_q_i, lane_q, size_q, uns_q);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      baddr_q      <= {ADDR_W{1'b0}};
      bdata_q      <= 32'd0;
      bsel_q       <= 4'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      baddr_q      <= baddr_d;
      bdata_q      <= bdata_d;
      bsel_q       <= bsel_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign resp_valid_o    = resp_valid_q;
  assign resp_err_o      = resp_err_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign mbus_addr_o     = baddr_q;
  assign mbus_data_d_o   = bdata_q;
  assign mbus_byte_sel_o = bsel_q;
  assign mbus_read_o     = rd_q;
  assign mbus_write_o    = wr_q;

endmodule
